pred_update_ctrl: RTL and testbench

PRED_UPDATE_CTRL -- requirements
Module: pred_update_ctrl

---
 rtl/pred_update_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_pred_update_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pred_update_ctrl.sv
// pred_update_ctrl
//   Arbitrates a single-ported branch predictor table between front-end
//   lookups and back-end updates. Resolved branches are queued in a small
//   FIFO and written back when no lookup claims the table; a starvation
//   counter forces an update slot after STARVE_LIMIT consecutive lookups
//   granted while updates are pending.
//
//   Parameters: PCW (PC index width), DEPTH (update FIFO depth, power of
//   two >= 2), STARVE_LIMIT (lookups allowed ahead of pending updates).
//
//   Ports:
//     clock, reset                  - rising-edge clock, sync active-low reset
//     lookup_valid/pc/ready         - lookup request handshake
//     resolve_valid/pc/taken/ready  - resolved-branch push handshake
//     flush                         - drop all pending updates
//     pred_valid, pred_taken        - prediction, 2 cycles after lookup accept
//     tbl_en/we/pc/taken, tbl_rdata - predictor table port (comb. read)
//
//   Optional macro UPD_BYPASS_EN: a lookup hitting a still-pending update
//   returns the youngest pending outcome instead of the stale table value.
module pred_update_ctrl #(
   parameter int PCW          = 10,
   parameter int DEPTH        = 4,
   parameter int STARVE_LIMIT = 3
) (
   input  logic           clock,
   input  logic           reset,
   input  logic           lookup_valid,
   input  logic [PCW-1:0] lookup_pc,
   output logic           lookup_ready,
   input  logic           resolve_valid,
   input  logic [PCW-1:0] resolve_pc,
   input  logic           resolve_taken,
   output logic           resolve_ready,
   input  logic           flush,
   output logic           pred_valid,
   output logic           pred_taken,
   output logic           tbl_en,
   output logic           tbl_we,
   output logic [PCW-1:0] tbl_pc,
   output logic           tbl_taken,
   input  logic           tbl_rdata
);

   localparam int PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNTW = PTRW + 1;
   localparam int SW   = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOOKUP,
      ST_UPDATE
   } state_t;

   typedef struct packed {
      logic [PCW-1:0] pc;
      logic           taken;
   } entry_t;

   state_t          state_q, state_d;
   entry_t          mem_q [DEPTH];
   logic [PTRW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTRW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNTW-1:0] count_q, count_d;
   logic [SW-1:0]   starve_q, starve_d;
   logic [PCW-1:0]  tbl_pc_q, tbl_pc_d;
   logic            tbl_taken_q, tbl_taken_d;
   logic            pred_valid_q, pred_valid_d;
   logic            pred_taken_q, pred_taken_d;

   logic            fifo_empty, fifo_full;
   logic            lookup_acc, push, pop;
   entry_t          head;

`ifdef UPD_BYPASS_EN
   logic            byp_hit, byp_taken;
   logic [PTRW-1:0] byp_idx;
`endif

   always_comb begin
      fifo_empty    = (count_q == '0);
      fifo_full     = (count_q == CNTW'(DEPTH));
      resolve_ready = !fifo_full;
      lookup_ready  = !(!fifo_empty && (fifo_full || starve_q == SW'(STARVE_LIMIT)));
      lookup_acc    = lookup_valid && lookup_ready;
      // flush suppresses both the same-cycle pop and the same-cycle push
      pop           = !lookup_acc && !fifo_empty && !flush;
      push          = resolve_valid && resolve_ready && !flush;
      head          = mem_q[rd_ptr_q];

      wr_ptr_d = push ? wr_ptr_q + PTRW'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + PTRW'(1) : rd_ptr_q;
      if (flush) begin
         count_d  = '0;
         rd_ptr_d = wr_ptr_q;
      end else begin
         count_d = count_q + CNTW'(push) - CNTW'(pop);
      end

      // Starvation counter measures lookups granted ahead of a pending update
      starve_d = starve_q;
      if (flush || pop || fifo_empty) begin
         starve_d = '0;
      end else if (lookup_acc && starve_q != SW'(STARVE_LIMIT)) begin
         starve_d = starve_q + SW'(1);
      end

      state_d     = ST_IDLE;
      tbl_pc_d    = tbl_pc_q;
      tbl_taken_d = tbl_taken_q;
      if (lookup_acc) begin
         state_d  = ST_LOOKUP;
         tbl_pc_d = lookup_pc;
      end else if (pop) begin
         state_d     = ST_UPDATE;
         tbl_pc_d    = head.pc;
         tbl_taken_d = head.taken;
      end

      pred_valid_d = (state_q == ST_LOOKUP);
      pred_taken_d = pred_taken_q;
`ifdef UPD_BYPASS_EN
      // Scan oldest to youngest over entries surviving this cycle's pop;
      // the last hit wins, giving the youngest matching outcome.
      byp_hit   = 1'b0;
      byp_taken = 1'b0;
      byp_idx   = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         byp_idx = rd_ptr_q + PTRW'(i);
         if ((CNTW'(i) < count_q) && !(pop && i == 0) && (mem_q[byp_idx].pc == tbl_pc_q)) begin
            byp_hit   = 1'b1;
            byp_taken = mem_q[byp_idx].taken;
         end
      end
      if (state_q == ST_LOOKUP) begin
         pred_taken_d = byp_hit ? byp_taken : tbl_rdata;
      end
`else
      if (state_q == ST_LOOKUP) begin
         pred_taken_d = tbl_rdata;
      end
`endif
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q      <= ST_IDLE;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         starve_q     <= '0;
         tbl_pc_q     <= '0;
         tbl_taken_q  <= 1'b0;
         pred_valid_q <= 1'b0;
         pred_taken_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         starve_q     <= starve_d;
         tbl_pc_q     <= tbl_pc_d;
         tbl_taken_q  <= tbl_taken_d;
         pred_valid_q <= pred_valid_d;
         pred_taken_q <= pred_taken_d;
      end
   end

   // Storage needs no reset: entries are only visible through count_q
   always_ff @(posedge clock) begin
      if (reset && push) begin
         mem_q[wr_ptr_q] <= '{pc: resolve_pc, taken: resolve_taken};
      end
   end

   always_comb begin
      tbl_en     = (state_q != ST_IDLE);
      tbl_we     = (state_q == ST_UPDATE);
      tbl_pc     = tbl_pc_q;
      tbl_taken  = tbl_taken_q;
      pred_valid = pred_valid_q;
      pred_taken = pred_taken_q;
   end

endmodule

// File: tb/tb_pred_update_ctrl.sv
// tb_pred_update_ctrl
//   Drives directed scenarios followed by randomized traffic into
//   pred_update_ctrl. A queue-based reference model tracks pending updates,
//   the starvation count, the table operation of each cycle and the
//   prediction pipeline; a bench-side predictor array supplies tbl_rdata.
module tb_pred_update_ctrl;

   localparam int PCW   = 10;
   localparam int DEPTH = 4;
   localparam int LIMIT = 3;

   logic           clock = 1'b0;
   logic           reset;
   logic           lookup_valid;
   logic [PCW-1:0] lookup_pc;
   logic           lookup_ready;
   logic           resolve_valid;
   logic [PCW-1:0] resolve_pc;
   logic           resolve_taken;
   logic           resolve_ready;
   logic           flush;
   logic           pred_valid;
   logic           pred_taken;
   logic           tbl_en;
   logic           tbl_we;
   logic [PCW-1:0] tbl_pc;
   logic           tbl_taken;
   logic           tbl_rdata;

   logic tbl_mem [2**PCW];
   assign tbl_rdata = tbl_mem[tbl_pc];

   always #5 clock = ~clock;

   pred_update_ctrl #(.PCW(PCW), .DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
      .clock(clock), .reset(reset),
      .lookup_valid(lookup_valid), .lookup_pc(lookup_pc), .lookup_ready(lookup_ready),
      .resolve_valid(resolve_valid), .resolve_pc(resolve_pc),
      .resolve_taken(resolve_taken), .resolve_ready(resolve_ready),
      .flush(flush), .pred_valid(pred_valid), .pred_taken(pred_taken),
      .tbl_en(tbl_en), .tbl_we(tbl_we), .tbl_pc(tbl_pc), .tbl_taken(tbl_taken),
      .tbl_rdata(tbl_rdata)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference model state
   typedef struct packed {
      logic [PCW-1:0] pc;
      logic           tk;
   } ent_t;

   ent_t           q[$];
   int             starve;
   int             op;          // 0 idle, 1 lookup, 2 update
   logic [PCW-1:0] op_pc;
   logic           op_tk;
   logic           m_pv, m_pt;
   bit             known = 0;

   int n_ready_low;   // cycles with lookup_ready low while lookup_valid
   int n_grant;
   int n_rr_low;
   int n_we;

   // Inputs are set at a negedge; this applies them across one rising edge.
   task automatic step();
      bit   lr, rr, la, pop, empty_pre;
      ent_t head;
      logic n_pv, n_pt;
      #1;
      lr = !(q.size() != 0 && (q.size() == DEPTH || starve == LIMIT));
      rr = (q.size() != DEPTH);
      if (known) begin
         check_eq("lookup_ready", lookup_ready, lr);
         check_eq("resolve_ready", resolve_ready, rr);
      end
      if (lookup_valid && !lookup_ready) n_ready_low++;
      if (lookup_valid && lookup_ready) n_grant++;
      if (!resolve_ready) n_rr_low++;
      if (!reset) begin
         q.delete();
         starve = 0; op = 0; op_pc = '0; op_tk = 1'b0; m_pv = 1'b0; m_pt = 1'b0;
         known = 1;
      end else begin
         empty_pre = (q.size() == 0);
         la   = lookup_valid && lr;
         pop  = !la && !empty_pre && !flush;
         n_pv = (op == 1);
         n_pt = m_pt;
         if (op == 2) tbl_mem[op_pc] = op_tk;
         head = empty_pre ? '0 : q[0];
         if (pop) void'(q.pop_front());
         if (op == 1) begin
            n_pt = tbl_mem[op_pc];
`ifdef UPD_BYPASS_EN
            foreach (q[i]) if (q[i].pc == op_pc) n_pt = q[i].tk;
`endif
         end
         if (flush || pop || empty_pre) starve = 0;
         else if (la && starve < LIMIT) starve++;
         if (flush) q.delete();
         else if (resolve_valid && rr) q.push_back('{pc: resolve_pc, tk: resolve_taken});
         if (la) begin
            op = 1; op_pc = lookup_pc;
         end else if (pop) begin
            op = 2; op_pc = head.pc; op_tk = head.tk;
         end else begin
            op = 0;
         end
         m_pv = n_pv;
         m_pt = n_pt;
      end
      @(negedge clock);
      if (tbl_we) n_we++;
      if (known) begin
         check_eq("tbl_en", tbl_en, op != 0);
         check_eq("tbl_we", tbl_we, op == 2);
         if (op != 0) check_eq("tbl_pc", tbl_pc, op_pc);
         if (op == 2) check_eq("tbl_taken", tbl_taken, op_tk);
         check_eq("pred_valid", pred_valid, m_pv);
         if (m_pv) check_eq("pred_taken", pred_taken, m_pt);
      end
   endtask

   task automatic idle_in();
      reset = 1'b1; lookup_valid = 1'b0; lookup_pc = '0;
      resolve_valid = 1'b0; resolve_pc = '0; resolve_taken = 1'b0; flush = 1'b0;
   endtask

   initial begin
      logic exp_byp;
      for (int i = 0; i < 2**PCW; i++) tbl_mem[i] = 1'($urandom);
      idle_in();

      // Reset: one edge low, then released
      reset = 1'b0;
      step();
      reset = 1'b1;
      check_eq("rst_tbl_en", tbl_en, 1'b0);
      check_eq("rst_tbl_we", tbl_we, 1'b0);
      check_eq("rst_tbl_pc", tbl_pc, '0);
      check_eq("rst_tbl_taken", tbl_taken, 1'b0);
      check_eq("rst_pred_valid", pred_valid, 1'b0);
      check_eq("rst_pred_taken", pred_taken, 1'b0);
      check_eq("rst_lookup_ready", lookup_ready, 1'b1);
      check_eq("rst_resolve_ready", resolve_ready, 1'b1);
      step();

      // Single lookup, pc=20, table holds 1
      tbl_mem[20] = 1'b1;
      lookup_valid = 1'b1; lookup_pc = PCW'(20);
      step();
      idle_in();
      check_eq("lk_tbl_en", tbl_en, 1'b1);
      check_eq("lk_tbl_pc", tbl_pc, 20);
      step();
      check_eq("lk_pred_valid", pred_valid, 1'b1);
      check_eq("lk_pred_taken", pred_taken, 1'b1);
      step();

      // One resolve, then continuous lookups: one forced update slot
      resolve_valid = 1'b1; resolve_pc = PCW'(10); resolve_taken = 1'b1;
      step();
      idle_in();
      n_ready_low = 0; n_grant = 0; n_we = 0;
      lookup_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         lookup_pc = PCW'(100 + i);
         step();
      end
      check_eq("starve_ready_low", n_ready_low, 1);
      check_eq("starve_grants", n_grant, 7);
      check_eq("starve_updates", n_we, 1);
      idle_in();
      step(); step();

      // Five resolves with lookups held: FIFO fills, back-pressure
      n_rr_low = 0;
      lookup_valid = 1'b1; resolve_valid = 1'b1;
      for (int i = 0; i < 12; i++) begin
         lookup_pc     = PCW'(200 + i);
         resolve_pc    = PCW'(1 + (i < 5 ? i : 4));
         resolve_taken = 1'(i);
         if (i >= 5) resolve_valid = 1'b0;
         step();
      end
      check_eq("full_backpressure", n_rr_low != 0, 1'b1);
      idle_in();
      for (int i = 0; i < 8; i++) step();

      // Three pending entries, then flush with a simultaneous resolve
      lookup_valid = 1'b1; resolve_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         lookup_pc  = PCW'(300 + i);
         resolve_pc = PCW'(i == 3 ? 99 : 30 + i);
         resolve_taken = 1'b1;
         flush = (i == 3);
         step();
      end
      idle_in();
      n_we = 0;
      check_eq("flush_ready", resolve_ready, 1'b1);
      for (int i = 0; i < 5; i++) step();
      check_eq("flush_no_update", n_we, 0);

      // Lookup hitting a pending update, table holds the opposite value
      tbl_mem[20] = 1'b1;
      lookup_valid = 1'b1; lookup_pc = PCW'(20);
      resolve_valid = 1'b1; resolve_pc = PCW'(20); resolve_taken = 1'b0;
      step();
      resolve_valid = 1'b0;
      step();
`ifdef UPD_BYPASS_EN
      exp_byp = 1'b0;
`else
      exp_byp = 1'b1;
`endif
      check_eq("byp_pred_valid", pred_valid, 1'b1);
      check_eq("byp_pred_taken", pred_taken, exp_byp);
      idle_in();
      for (int i = 0; i < 6; i++) step();

      // Randomized traffic, small PC range to force collisions
      for (int i = 0; i < 3000; i++) begin
         reset         = ($urandom_range(0, 199) != 0);
         lookup_valid  = ($urandom_range(0, 3) != 0);
         lookup_pc     = PCW'($urandom_range(0, 7));
         resolve_valid = ($urandom_range(0, 2) != 0);
         resolve_pc    = PCW'($urandom_range(0, 7));
         resolve_taken = 1'($urandom);
         flush         = ($urandom_range(0, 39) == 0);
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
